// File: rtl/serial_port.sv
// serial_port: byte-wide processor interface to an 8N1 UART.
//   TX: TX_DEPTH-entry FIFO feeding a registered transmitter.
//   RX: 2-flop synchronizer, mid-bit sampling receiver, single holding
//       register with sticky overrun and one-cycle frame error pulse.
// Optional build macro SERIAL_LOOPBACK_EN: the internal TX line drives the
// RX synchronizer, uart_rxd is ignored and uart_txd is held high.
module serial_port #(
  parameter int CLKS_PER_BIT = 16,
  parameter int TX_DEPTH     = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  output logic       wr_ready,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       uart_txd,
  input  logic       uart_rxd,
  output logic       overrun,
  output logic       frame_err
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // ---------------- TX FIFO ----------------
  logic [7:0]  mem_q [TX_DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        rdy_q;
  logic        full, empty, push, pop;

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  // rdy_q keeps wr_ready low in reset and for the first edge afterwards
  assign wr_ready = rdy_q & ~full;
  assign push     = wr_en & wr_ready;

  // FIFO storage: data only, no reset needed
  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= wr_data;
  end

  // ---------------- TX FSM ----------------
  tx_state_e     tx_st_q, tx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          txd_q, txd_d;
  logic          tx_tick;

  assign tx_tick = (tx_cnt_q == BIT_LAST);

  // TX next state: pops the FIFO from IDLE or straight out of STOP
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q + 1'b1;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    txd_d    = txd_q;
    pop      = 1'b0;
    unique case (tx_st_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (!empty) begin
          pop      = 1'b1;
          tx_sh_d  = mem_q[rptr_q[AW-1:0]];
          tx_st_d  = TX_START;
          txd_d    = 1'b0;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_cnt_d = '0;
          tx_bit_d = '0;
          tx_st_d  = TX_DATA;
          txd_d    = tx_sh_q[0];
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_st_d = TX_STOP;
            txd_d   = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            txd_d    = tx_sh_q[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_tick) begin
          tx_cnt_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            tx_sh_d = mem_q[rptr_q[AW-1:0]];
            tx_st_d = TX_START;
            txd_d   = 1'b0;
          end else begin
            tx_st_d = TX_IDLE;
          end
        end
      end
      default: tx_st_d = TX_IDLE;
    endcase
  end

  // TX and FIFO pointer registers; reset aborts any frame in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_st_q  <= TX_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      txd_q    <= 1'b1;
      wptr_q   <= '0;
      rptr_q   <= '0;
      rdy_q    <= 1'b0;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q  <= tx_sh_d;
      txd_q    <= txd_d;
      rdy_q    <= 1'b1;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // ---------------- line routing ----------------
  logic rx_line;
`ifdef SERIAL_LOOPBACK_EN
  logic unused_rxd;
  assign unused_rxd = uart_rxd;
  assign rx_line    = txd_q;
  assign uart_txd   = 1'b1;
`else
  assign rx_line    = uart_rxd;
  assign uart_txd   = txd_q;
`endif

  // ---------------- RX ----------------
  logic          sync0_q, sync1_q, prev_q;
  rx_state_e     rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d, overrun_q, overrun_d, ferr_q, ferr_d;
  logic          rx_s, done;

  assign rx_s = sync1_q;

  // RX next state, holding register and status flags
  always_comb begin
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    overrun_d  = overrun_q;
    ferr_d     = 1'b0;
    done       = 1'b0;
    unique case (rx_st_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        // edge, not level, so a low stop bit cannot retrigger a frame
        if (prev_q && !rx_s) rx_st_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_st_d  = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
          else                  rx_bit_d = rx_bit_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          rx_st_d  = RX_IDLE;
          if (rx_s) done   = 1'b1;
          else      ferr_d = 1'b1;
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
    if (done) begin
      rd_data_d  = rx_sh_q;
      rd_valid_d = 1'b1;
      if (rd_valid_q && !rd_en) overrun_d = 1'b1;
    end else if (rd_en && rd_valid_q) begin
      rd_valid_d = 1'b0;
    end
  end

  // RX registers including synchronizer (idle-high)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync0_q    <= 1'b1;
      sync1_q    <= 1'b1;
      prev_q     <= 1'b1;
      rx_st_q    <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync0_q    <= rx_line;
      sync1_q    <= sync0_q;
      prev_q     <= rx_s;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overrun_q  <= overrun_d;
      ferr_q     <= ferr_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_serial_port.sv
// Bench for serial_port: TX FIFO/timing reference model with a scoreboard,
// line-level TX and RX monitors, randomized traffic.
module tb_serial_port;
  localparam int C = 16;
  localparam int D = 4;

  logic       clock = 1'b0, reset = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_en = 1'b0, rd_en = 1'b0, uart_rxd = 1'b1;
  logic       wr_ready, rd_valid, uart_txd, overrun, frame_err;
  logic [7:0] rd_data;

  serial_port #(.CLKS_PER_BIT(C), .TX_DEPTH(D)) dut (
    .clock(clock), .reset(reset), .wr_data(wr_data), .wr_en(wr_en),
    .wr_ready(wr_ready), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .uart_txd(uart_txd), .uart_rxd(uart_rxd), .overrun(overrun),
    .frame_err(frame_err));

  always #5 clock = ~clock;

  int total = 0, bad = 0;
  logic [7:0]  mq[$];      // model FIFO contents
  logic [7:0]  tx_exp[$];  // bytes expected on the line, in order
  longint      exp_st[$];  // expected time the start bit is seen
  logic [8:0]  rxq[$];     // {frame error, byte} expected from RX
  bit          mon_en = 1'b0, rx_auto = 1'b0;
  int          ecnt = 0, last_pop = -100000;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", n, act, exp, $time);
    end
  endtask

  task automatic fail(input string n);
    total++; bad++;
    $display("FAIL %s actual=event expected=none @%0t", n, $time);
  endtask

  // One TX-side clock: drive inputs, check wr_ready, advance the model.
  // A frame occupies the transmitter for 10*C edges; a queued byte is
  // taken at the first edge where the line is free and the FIFO non-empty.
  task automatic tx_cycle(input logic en, input logic [7:0] d);
    logic pop, push;
    @(negedge clock);
    wr_en = en; wr_data = d;
    chk("wr_ready", wr_ready, (mq.size() < D));
    pop  = (mq.size() > 0) && (ecnt >= last_pop + 10*C);
    push = en && (mq.size() < D);
    if (pop) begin
      last_pop = ecnt;
      tx_exp.push_back(mq.pop_front());
      exp_st.push_back($time + 10);
    end
    if (push) mq.push_back(d);
    ecnt++;
  endtask

  task automatic drain();
    for (int k = 0; k < 6000 && (mq.size() + tx_exp.size()) > 0; k++) tx_cycle(1'b0, 8'h00);
    chk("tx_drained", mq.size() + tx_exp.size(), 0);
    repeat (10*C) tx_cycle(1'b0, 8'h00);
  endtask

  task automatic model_clear();
    mq.delete(); tx_exp.delete(); exp_st.delete(); rxq.delete();
    last_pop = -100000;
  endtask

  task automatic do_reset();
    rx_auto = 1'b0; mon_en = 1'b0; wr_en = 1'b0; rd_en = 1'b0; uart_rxd = 1'b1;
    @(negedge clock); reset = 1'b0; #1;
    chk("rst_txd", uart_txd, 1); chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0); chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_overrun", overrun, 0); chk("rst_frame_err", frame_err, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1; model_clear(); #1;
    chk("rdy_before_edge", wr_ready, 0);
    mon_en = 1'b1;
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop);
    @(negedge clock); uart_rxd = 1'b0;
    repeat (C - 1) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock); uart_rxd = d[i];
      repeat (C - 1) @(negedge clock);
    end
    @(negedge clock); uart_rxd = stop;
    repeat (C - 1) @(negedge clock);
    @(negedge clock); uart_rxd = 1'b1;
  endtask

  // TX line monitor: decodes frames at mid-bit and scores them
  initial begin : tx_mon
    logic prev; logic [7:0] b, ed; longint t0; bit have;
    prev = 1'b1;
    forever begin
      @(negedge clock);
      if (mon_en && prev && !uart_txd) begin
        t0 = $time; have = (tx_exp.size() > 0);
        if (!have) fail("tx_unexpected_frame");
        else begin
          ed = tx_exp.pop_front();
          chk("tx_start_time", t0, exp_st.pop_front());
        end
        repeat (C/2) @(negedge clock);
        chk("tx_start_bit", uart_txd, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clock);
          b[i] = uart_txd;
        end
        repeat (C) @(negedge clock);
        chk("tx_stop_bit", uart_txd, 1);
        if (have) chk("tx_data", b, ed);
      end
      prev = uart_txd;
    end
  end

  // RX monitor: consumes every byte/error the DUT presents in auto mode
  initial begin : rx_mon
    logic [8:0] e;
    forever begin
      @(negedge clock);
      if (rx_auto) begin
        if (frame_err) begin
          if (rxq.size() == 0) fail("rx_unexpected_ferr");
          else begin
            e = rxq.pop_front();
            chk("rx_ferr", frame_err, e[8]);
            chk("rx_ferr_no_valid", rd_valid, 0);
          end
        end else if (rd_valid) begin
          if (rxq.size() == 0) fail("rx_unexpected_byte");
          else begin
            e = rxq.pop_front();
            chk("rx_ferr", frame_err, e[8]);
            chk("rx_data", rd_data, e[7:0]);
            chk("rx_overrun", overrun, 0);
          end
          rd_en = 1'b1;
          @(negedge clock); rd_en = 1'b0;
          chk("rx_read_clears", rd_valid, 0);
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin : main
    int hi, pulses, got, txbad;
    logic [7:0] d; logic ok;
    do_reset();
`ifdef SERIAL_LOOPBACK_EN
    uart_rxd = 1'b0;
    mon_en = 1'b0;
    tx_cycle(1'b1, 8'h3C);
    tx_cycle(1'b0, 8'h00);
    got = 0; txbad = 0;
    for (int k = 0; k < 10*C + 8 && got == 0; k++) begin
      @(negedge clock);
      if (!uart_txd) txbad++;
      if (rd_valid) got = 1;
    end
    chk("lb_rd_valid", got, 1);
    chk("lb_rd_data", rd_data, 8'h3C);
    chk("lb_txd_high", txbad, 0);
`else
    // single byte: latency, bit order, frame length via start times
    tx_cycle(1'b1, 8'h55);
    drain();
    tx_cycle(1'b1, 8'hC3);
    drain();
    // wr_en held for 8 cycles: FIFO fills, extra writes dropped
    for (int i = 1; i <= 8; i++) tx_cycle(1'b1, 8'(i));
    drain();
    // random sparse writes, often against a full FIFO
    repeat (2500) tx_cycle($urandom_range(39) == 0, 8'($urandom));
    drain();

    // reset in the middle of data bit 3, with a byte still queued
    mon_en = 1'b0;
    tx_cycle(1'b1, 8'h00);
    tx_cycle(1'b1, 8'h81);
    repeat (4*C + C/2) tx_cycle(1'b0, 8'h00);
    chk("rst_mid_frame_low", uart_txd, 0);
    #1 reset = 1'b0; #1;
    chk("rst_abort_txd", uart_txd, 1);
    chk("rst_abort_rdy", wr_ready, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1; model_clear(); #1;
    chk("rst_rdy_low", wr_ready, 0);
    @(negedge clock);
    chk("rst_rdy_edge", wr_ready, 1);
    mon_en = 1'b1;
    hi = 0;
    for (int k = 0; k < 400; k++) begin
      tx_cycle(1'b0, 8'h00);
      hi += int'(uart_txd);
    end
    chk("rst_no_frame", hi, 400);

    // RX: single byte and read
    do_reset();
    rx_frame(8'hA3, 1'b1);
    chk("rx_a3_valid", rd_valid, 1);
    chk("rx_a3_data", rd_data, 8'hA3);
    rd_en = 1'b1;
    @(negedge clock); rd_en = 1'b0;
    chk("rx_a3_cleared", rd_valid, 0);
    // overrun and frame error
    rx_frame(8'h11, 1'b1);
    chk("rx_11_data", rd_data, 8'h11);
    chk("rx_11_overrun", overrun, 0);
    rx_frame(8'h22, 1'b1);
    chk("ovr_data", rd_data, 8'h22);
    chk("ovr_valid", rd_valid, 1);
    chk("ovr_flag", overrun, 1);
    pulses = 0;
    fork
      rx_frame(8'h5A, 1'b0);
      begin
        repeat (11*C) begin
          @(negedge clock);
          if (frame_err) pulses++;
        end
      end
    join
    chk("ferr_pulse_len", pulses, 1);
    chk("ferr_data_kept", rd_data, 8'h22);
    chk("ferr_valid_kept", rd_valid, 1);
    chk("ovr_sticky", overrun, 1);

    // RX: glitch rejection then random frames with occasional bad stops
    do_reset();
    rx_auto = 1'b1;
    @(negedge clock); uart_rxd = 1'b0;
    repeat (4) @(negedge clock);
    uart_rxd = 1'b1;
    repeat (12*C) @(negedge clock);
    chk("rx_glitch", rd_valid, 0);
    repeat (24) begin
      d = 8'($urandom);
      ok = ($urandom_range(4) != 0);
      rxq.push_back({~ok, d});
      rx_frame(d, ok);
      repeat ($urandom_range(20, 2)) @(negedge clock);
    end
    for (int k = 0; k < 4*C && rxq.size() > 0; k++) @(negedge clock);
    chk("rx_drained", rxq.size(), 0);
    rx_auto = 1'b0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_port.md
SERIAL_PORT -- requirements
Module: serial_port

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per UART bit (minimum 4, even).
REQ-002 SHALL have parameter TX_DEPTH, default 4, meaning TX FIFO entries (power of two, at least 2).
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port wr_data, input, 8, byte from the processor serial_out.
REQ-006 SHALL have port wr_en, input, 1, processor write strobe (serial_wren_out).
REQ-007 SHALL have port wr_ready, output, 1, space available (drives processor serial_ready_in).
REQ-008 SHALL have port rd_en, input, 1, processor read strobe (serial_rden_out).
REQ-009 SHALL have port rd_data, output, 8, received byte (drives processor serial_in).
REQ-010 SHALL have port rd_valid, output, 1, rd_data holds an unread byte (drives serial_valid_in).
REQ-011 SHALL have port uart_txd, output, 1, serial line out, idle high.
REQ-012 SHALL have port uart_rxd, input, 1, serial line in, asynchronous to clock.
REQ-013 SHALL have port overrun, output, 1, sticky flag: an unread byte was overwritten.
REQ-014 SHALL have port frame_err, output, 1, one-cycle pulse on a bad stop bit.

Function
REQ-015 SHALL accept a write when wr_en=1 and wr_ready=1 at a rising edge; wr_en with wr_ready=0 SHALL be ignored, with no FIFO change.
REQ-016 SHALL drive wr_ready = not full; a push and a pop in the same cycle SHALL both succeed when the FIFO is not full.
REQ-017 SHALL use TX FSM states IDLE, START, DATA, STOP; each bit SHALL last exactly CLKS_PER_BIT cycles; frame = start 0, 8 data bits LSB first, stop 1.
REQ-018 SHALL pop the FIFO in IDLE when it is non-empty and drive uart_txd low from the next edge, so the start bit begins one cycle after the write into an empty FIFO.
REQ-019 SHALL go from STOP directly to START, with no idle gap, when the FIFO is non-empty at the end of the stop bit; otherwise it SHALL go to IDLE.
REQ-020 SHALL register uart_txd so it is glitch-free.
REQ-021 SHALL pass uart_rxd through a 2-flop synchronizer before the RX FSM.
REQ-022 SHALL use RX FSM states IDLE, START, DATA, STOP; a falling edge in IDLE SHALL enter START; the line SHALL be sampled at CLKS_PER_BIT/2, and if high, return to IDLE (glitch reject).
REQ-023 SHALL sample each data bit and the stop bit CLKS_PER_BIT cycles after the previous sample.
REQ-024 SHALL, on stop=1, load rd_data and set rd_valid=1 on the following edge; on stop=0 it SHALL discard the byte, pulse frame_err for one cycle and leave rd_valid unchanged.
REQ-025 SHALL clear rd_valid on the edge after a cycle with rd_en=1 and rd_valid=1; rd_en with rd_valid=0 SHALL be ignored.
REQ-026 SHALL, when a new byte completes while rd_valid=1 and rd_en=0, overwrite rd_data and set overrun (sticky until reset).
REQ-027 SHALL, when a byte completes in the same cycle as rd_en, load the new byte, keep rd_valid=1 and leave overrun unchanged.

Reset
REQ-028 SHALL, while reset=0, force uart_txd=1, wr_ready=0, rd_valid=0, rd_data=0x00, overrun=0, frame_err=0, both FSMs to IDLE and the FIFO to empty.
REQ-029 SHALL, on reset assertion mid-frame, abort the frame immediately (uart_txd high) and discard FIFO contents; wr_ready SHALL rise on the first edge after deassertion.

Configuration
REQ-030 SHALL, with SERIAL_LOOPBACK_EN defined, feed the internal TX line to the RX synchronizer, ignore uart_rxd and hold uart_txd=1.
REQ-031 SHALL, without SERIAL_LOOPBACK_EN, connect RX to uart_rxd and TX to uart_txd normally.

Verification
REQ-032 SHALL cover: reset, then write 0x55 -> uart_txd low one cycle after the write; bits 1,0,1,0,1,0,1,0, then stop high; frame 160 cycles; wr_ready=1 throughout.
REQ-033 SHALL cover: wr_en held high for 8 cycles with data 0x01..0x08 -> wr_ready drops when the FIFO is full; only accepted bytes appear on uart_txd, in order and contiguous with no gaps.
REQ-034 SHALL cover: drive an rxd frame 0xA3 at 16 cycles/bit -> rd_valid=1 with rd_data=0xA3; one-cycle rd_en -> rd_valid=0 on the next edge.
REQ-035 SHALL cover: rx frames 0x11 then 0x22 with no rd_en -> rd_data=0x22, rd_valid=1, overrun=1; and a frame with stop=0 -> frame_err one-cycle pulse, rd_data unchanged.
REQ-036 SHALL cover: SERIAL_LOOPBACK_EN defined, write 0x3C -> rd_valid=1 with rd_data=0x3C within 10*16+8 cycles; uart_txd stays 1.
REQ-037 SHALL cover: assert reset during data bit 3 of a frame -> uart_txd=1 immediately; no further frame after deassertion; wr_ready=1 one edge later.
